// File: rtl/ft_alu_result_monitor.sv
// Registered checker behind the fault-tolerant 3-bit ALU: validates rails and X==Y, retries, flags faults.
// Optional FT_MON_TMR_STATE_EN triplicates and scrubs the state and retry registers.
module ft_alu_result_monitor #(
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       x_res,
  input  logic [1:0]       xe,
  input  logic [3:0]       y_res,
  input  logic [1:0]       ye,
  output logic             retry_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_res,
  output logic             out_err,
  output logic             fault_sticky,
  output logic [CNT_W-1:0] fault_cnt,
  input  logic             clr_fault,
  output logic             tmr_mismatch
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    OUTPUT = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_t     state, state_d;
  logic [2:0] retry, retry_d;

  logic [3:0] cap_x, cap_y;
  logic [1:0] cap_xe, cap_ye;
  logic       pass;
  logic       load_out, err_set, cnt_inc, clr_sticky;

`ifdef FT_MON_TMR_STATE_EN
  logic [1:0] st0, st1, st2;
  logic [2:0] rc0, rc1, rc2;

  assign state = state_t'((st0 & st1) | (st0 & st2) | (st1 & st2));
  assign retry = (rc0 & rc1) | (rc0 & rc2) | (rc1 & rc2);
  assign tmr_mismatch = (st0 != state) | (st1 != state) | (st2 != state)
                      | (rc0 != retry) | (rc1 != retry) | (rc2 != retry);

  // All copies load the next value derived from the vote, scrubbing upsets
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st0 <= IDLE;
      st1 <= IDLE;
      st2 <= IDLE;
      rc0 <= '0;
      rc1 <= '0;
      rc2 <= '0;
    end else begin
      st0 <= state_d;
      st1 <= state_d;
      st2 <= state_d;
      rc0 <= retry_d;
      rc1 <= retry_d;
      rc2 <= retry_d;
    end
  end
`else
  assign tmr_mismatch = 1'b0;

  // Single state and retry register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      retry <= '0;
    end else begin
      state <= state_d;
      retry <= retry_d;
    end
  end
`endif

  assign pass = (^cap_xe) & (^cap_ye) & (cap_x == cap_y);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUTPUT);

  // Next-state, retry pulse and datapath strobes
  always_comb begin
    state_d    = state;
    retry_d    = retry;
    retry_req  = 1'b0;
    load_out   = 1'b0;
    err_set    = 1'b0;
    cnt_inc    = 1'b0;
    clr_sticky = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) state_d = CHECK;
      end
      CHECK: begin
        if (pass) begin
          load_out = 1'b1;
          retry_d  = '0;
          state_d  = OUTPUT;
        end else if (retry < MAX_R) begin
          retry_d   = retry + 3'd1;
          retry_req = 1'b1;
          cnt_inc   = 1'b1;
          state_d   = IDLE;
        end else begin
          load_out = 1'b1;
          err_set  = 1'b1;
          cnt_inc  = 1'b1;
          retry_d  = '0;
          state_d  = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) state_d = fault_sticky ? FAULT : IDLE;
      end
      FAULT: begin
        if (clr_fault) begin
          clr_sticky = 1'b1;
          retry_d    = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        retry_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Capture the presented ALU outputs on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_x  <= '0;
      cap_y  <= '0;
      cap_xe <= '0;
      cap_ye <= '0;
    end else if (in_ready && in_valid) begin
      cap_x  <= x_res;
      cap_y  <= y_res;
      cap_xe <= xe;
      cap_ye <= ye;
    end
  end

  // Result register, sticky fault and saturating failure count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_res      <= '0;
      out_err      <= 1'b0;
      fault_sticky <= 1'b0;
      fault_cnt    <= '0;
    end else begin
      if (load_out) begin
        out_res <= cap_x;
        out_err <= err_set;
      end
      if (err_set) fault_sticky <= 1'b1;
      else if (clr_sticky) fault_sticky <= 1'b0;
      if (cnt_inc && !(&fault_cnt)) fault_cnt <= fault_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ft_alu_result_monitor.sv
// Directed self-checking bench for ft_alu_result_monitor.
// A second instance with CNT_W=2 shares stimulus to observe counter saturation.
module tb_ft_alu_result_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready, clr_fault;
  logic [3:0] x_res, y_res;
  logic [1:0] xe, ye;

  logic       in_ready, retry_req, out_valid, out_err, fault_sticky, tmr_mismatch;
  logic [3:0] out_res;
  logic [7:0] fault_cnt;

  logic       s_in_ready, s_retry_req, s_out_valid, s_out_err, s_sticky, s_tmr;
  logic [3:0] s_out_res;
  logic [1:0] s_fault_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ft_alu_result_monitor #(.MAX_RETRY(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_res(x_res), .xe(xe), .y_res(y_res), .ye(ye),
    .retry_req(retry_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_err(out_err), .fault_sticky(fault_sticky),
    .fault_cnt(fault_cnt), .clr_fault(clr_fault), .tmr_mismatch(tmr_mismatch)
  );

  ft_alu_result_monitor #(.MAX_RETRY(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .x_res(x_res), .xe(xe), .y_res(y_res), .ye(ye),
    .retry_req(s_retry_req), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_res(s_out_res), .out_err(s_out_err), .fault_sticky(s_sticky),
    .fault_cnt(s_fault_cnt), .clr_fault(clr_fault), .tmr_mismatch(s_tmr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic [3:0] x, input logic [1:0] ex,
                         input logic [3:0] y, input logic [1:0] ey);
    x_res = x; xe = ex; y_res = y; ye = ey; in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; out_ready = 0; clr_fault = 0;
    x_res = 0; y_res = 0; xe = 0; ye = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_fault_cnt", fault_cnt, 0);
    chk("rst_sticky", fault_sticky, 0);
    rst = 1'b0;
    step();

    // clean transaction
    present(4'h5, 2'b01, 4'h5, 2'b01);
    step();
    in_valid = 0;
    chk("t1_in_ready_check", in_ready, 0);
    chk("t1_no_retry", retry_req, 0);
    chk("t1_not_valid_yet", out_valid, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_res", out_res, 4'h5);
    chk("t1_out_err", out_err, 0);
    chk("t1_fault_cnt", fault_cnt, 0);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t1_back_idle", in_ready, 1);
    chk("t1_out_valid_low", out_valid, 0);

    // bad rail once, then clean
    present(4'h6, 2'b11, 4'h6, 2'b10);
    step();
    in_valid = 0;
    chk("t2_retry_pulse", retry_req, 1);
    step();
    chk("t2_pulse_gone", retry_req, 0);
    chk("t2_fault_cnt", fault_cnt, 1);
    chk("t2_idle", in_ready, 1);
    present(4'h6, 2'b01, 4'h6, 2'b10);
    step();
    in_valid = 0;
    chk("t2_no_retry", retry_req, 0);
    step();
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_res", out_res, 4'h6);
    chk("t2_out_err", out_err, 0);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t2_idle_after", in_ready, 1);

    // persistent mismatch exhausts retries
    for (int i = 0; i < 2; i++) begin
      present(4'h3, 2'b01, 4'h7, 2'b01);
      step();
      in_valid = 0;
      chk("t3_retry_pulse", retry_req, 1);
      step();
    end
    chk("t3_fault_cnt_mid", fault_cnt, 3);
    present(4'h3, 2'b01, 4'h7, 2'b01);
    step();
    in_valid = 0;
    chk("t3_no_third_pulse", retry_req, 0);
    step();
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_res", out_res, 4'h3);
    chk("t3_out_err", out_err, 1);
    chk("t3_sticky", fault_sticky, 1);
    chk("t3_fault_cnt", fault_cnt, 4);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t3_fault_in_ready", in_ready, 0);
    chk("t3_fault_out_valid", out_valid, 0);
    present(4'h1, 2'b01, 4'h1, 2'b01);
    step();
    in_valid = 0;
    chk("t3_fault_ignores_in", in_ready, 0);
    clr_fault = 1;
    step();
    clr_fault = 0;
    chk("t3_cleared_ready", in_ready, 1);
    chk("t3_cleared_sticky", fault_sticky, 0);

    // backpressure in OUTPUT
    present(4'h9, 2'b10, 4'h9, 2'b01);
    step();
    in_valid = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      present(4'(i), 2'b00, 4'hF, 2'b11);
      step();
      chk("t4_hold_res", out_res, 4'h9);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t4_idle", in_ready, 1);
    chk("t4_valid_low", out_valid, 0);
    chk("t4_cnt_unchanged", fault_cnt, 4);

    // fifth failure: saturation on the narrow counter
    present(4'h1, 2'b01, 4'h2, 2'b01);
    step();
    in_valid = 0;
    chk("t5_retry_pulse", retry_req, 1);
    step();
    chk("t5_cnt_wide", fault_cnt, 5);
    chk("t5_cnt_sat", s_fault_cnt, 2'b11);

    // reset during CHECK
    present(4'h1, 2'b01, 4'h2, 2'b01);
    step();
    in_valid = 0;
    chk("t6_pre_rst_pulse", retry_req, 1);
    rst = 1;
    #1;
    chk("t6_rst_no_retry", retry_req, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    chk("t6_rst_cnt", fault_cnt, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 0;
    step();
    present(4'hA, 2'b01, 4'hA, 2'b01);
    step();
    in_valid = 0;
    step();
    chk("t6_after_rst_valid", out_valid, 1);
    chk("t6_after_rst_res", out_res, 4'hA);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t6_after_rst_idle", in_ready, 1);

`ifdef FT_MON_TMR_STATE_EN
    dut.st1 = 2'd3;
    #1;
    chk("tmr_flag", tmr_mismatch, 1);
    chk("tmr_vote_idle", in_ready, 1);
    step();
    chk("tmr_scrubbed", tmr_mismatch, 0);
    chk("tmr_still_idle", in_ready, 1);
`else
    chk("tmr_tied_low", tmr_mismatch, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
